mdu_muldiv: RTL

Multi-cycle multiply/divide unit for the MIPS datapath, sitting in the execute stage beside the ALU. It consumes the two register-file read operands, rdA and rdB. It computes MULT, MULTU, DIV or DIVU iteratively, one bit per clock, into architectural HI/LO registers. The control path stalls on `busy` and reads results for MFHI/MFLO.

---
 rtl/mdu_muldiv.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mdu_muldiv.sv
// Iterative MIPS multiply/divide unit: one bit per clock into architectural HI/LO.
// Shift-add multiply (LSB first) and restoring divide (MSB first) on magnitudes, sign fixed at the end.
module mdu_muldiv #(
    parameter int unsigned N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wd,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         busy,
    output logic         done
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_d;

    logic          is_div;
    logic          neg_q;
    logic          neg_r;
    logic [CW-1:0] cnt;
    logic [2*N-1:0] mcand;
    logic [2*N-1:0] acc;
    logic [N-1:0]  mplier;
    logic [N-1:0]  rem;
    logic [N-1:0]  dvd;

    logic [N:0]    shifted;
    logic [N:0]    trial;

    function automatic logic [N-1:0] magnitude(input logic [N-1:0] x, input logic sgn);
        return (sgn && x[N-1]) ? -x : x;
    endfunction

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt == CW'(N - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Restoring-divide trial subtract; the 33-bit width keeps the borrow visible
    always_comb begin
        shifted = {rem, dvd[N-1]};
        trial   = shifted - {1'b0, mplier};
    end

    // Datapath, HI/LO and status flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            rem    <= '0;
            dvd    <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_d != IDLE);
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        mcand  <= {{N{1'b0}}, magnitude(inA, op[0])};
                        mplier <= magnitude(inB, op[0]);
                        dvd    <= magnitude(inA, op[0]);
                        acc    <= '0;
                        rem    <= '0;
                        cnt    <= '0;
                        // Divide-by-zero keeps an all-ones quotient, so its sign is never applied
                        neg_q  <= op[0] & (inA[N-1] ^ inB[N-1]) & (~op[1] | (inB != '0));
                        neg_r  <= op[0] & op[1] & inA[N-1];
                    end else begin
                        if (hi_we) hi <= wd;
                        if (lo_we) lo <= wd;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (!is_div) begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        rem <= trial[N] ? shifted[N-1:0] : trial[N-1:0];
                        dvd <= {dvd[N-2:0], ~trial[N]};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi <= neg_r ? -rem : rem;
                        lo <= neg_q ? -dvd : dvd;
                    end else begin
                        {hi, lo} <= neg_q ? -acc : acc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
